sub_shift_rows: RTL

//  Iterative AES SubBytes + ShiftRows stage. It sits directly upstream of mixColumns.
//  It accepts one 128-bit state block and substitutes BYTES_PER_CYCLE bytes per cycle

---
 rtl/sub_shift_rows.sv | 96 +++++++++
 1 files changed

// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes + ShiftRows: BYTES_PER_CYCLE S-box lookups per cycle, each byte written
// straight to its ShiftRows position; the finished block is offered on a valid/ready handshake.
module sub_shift_rows #(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CW        = $clog2(NUM_STEPS) + 1;
  localparam logic [CW-1:0] LastStep = CW'(NUM_STEPS - 1);

  // FIPS-197 forward S-box, entry x at bits [2047-8x -: 8]
  localparam logic [2047:0] SboxRom = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxRom[2047 - 8 * 32'(x) -: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic [127:0]  blk_q, blk_d;
  logic [127:0]  res_q, res_d;
  int unsigned   src_idx, dst_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      blk_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    blk_d   = blk_q;
    res_d   = res_q;
    src_idx = 0;
    dst_idx = 0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          blk_d   = in_data;
          step_d  = '0;
          state_d = StSub;
        end
      end
      StSub: begin
        for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
          src_idx = 32'(step_q) * BYTES_PER_CYCLE + j;
          // source (r,c) lands at (r, (c-r) mod 4)
          dst_idx = 4 * (((src_idx / 4) + 4 - (src_idx % 4)) % 4) + (src_idx % 4);
          res_d[127 - 8 * dst_idx -: 8] = sbox(blk_q[127 - 8 * src_idx -: 8]);
        end
        step_d = step_q + 1'b1;
        if (step_q == LastStep) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = res_q;

endmodule
